// File: rtl/prog_loader.sv
// -----------------------------------------------------------------------------
// prog_loader
//   Writer side of the instruction memory. Takes a program as a byte stream
//   (valid/ready), packs every three bytes little-endian into one instruction
//   word and issues single-cycle writes at MEM_BASE_ADDR + n. o_busy holds the
//   core's fetch path off while a load is in progress.
//
// Handshake: a byte is transferred on a rising edge where i_byte_valid and
//   o_byte_ready are both 1. o_byte_ready is registered and depends only on the
//   loader state, never on i_byte_valid. A source may raise i_byte_valid at any
//   time and must hold i_byte stable until the transfer edge.
//
// Ports
//   i_clk, i_rst      clock (rising edge), asynchronous active-high reset
//   i_start           1-cycle load request; sampled only in IDLE/DONE
//   i_word_count      instructions to load, latched with i_start
//   i_byte_valid      byte source valid
//   i_byte            byte data
//   o_byte_ready      loader accepts a byte
//   o_wr_en           instruction memory write strobe (one cycle per word)
//   o_wr_addr         write address (holds last value between writes)
//   o_wr_data         write data (holds last value between writes)
//   o_busy            load in progress
//   o_done            load finished; held until next accepted i_start/reset
//   o_error           load rejected or checksum failed; held like o_done
//   o_dbg_state       current FSM state encoding
//   o_dbg_byte        last accepted byte
//
// Configuration
//   PROG_LOADER_CHECKSUM_EN  when defined, a running XOR of every accepted
//   byte is kept and one extra checksum byte is taken after the last write.
// -----------------------------------------------------------------------------
module prog_loader #(
    parameter int INSTRUCTION_MEM_SIZE   = 8192,
    parameter int INSTRUCTION_WIDTH      = 18,
    parameter int INSTRUCTION_ADDR_WIDTH = 14,
    parameter logic [INSTRUCTION_ADDR_WIDTH-1:0] MEM_BASE_ADDR = 14'h2000
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic                              i_start,
    input  logic [INSTRUCTION_ADDR_WIDTH-1:0] i_word_count,
    input  logic                              i_byte_valid,
    input  logic [7:0]                        i_byte,
    output logic                              o_byte_ready,
    output logic                              o_wr_en,
    output logic [INSTRUCTION_ADDR_WIDTH-1:0] o_wr_addr,
    output logic [INSTRUCTION_WIDTH-1:0]      o_wr_data,
    output logic                              o_busy,
    output logic                              o_done,
    output logic                              o_error,
    output logic [2:0]                        o_dbg_state,
    output logic [7:0]                        o_dbg_byte
);

    localparam int AW = INSTRUCTION_ADDR_WIDTH;

    // One extra bit so a count equal to the memory size is representable.
    localparam logic [AW:0] MEM_SIZE_L = (AW+1)'(INSTRUCTION_MEM_SIZE);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_B0   = 3'd1,
        S_B1   = 3'd2,
        S_B2   = 3'd3,
        S_WR   = 3'd4,
        S_CHK  = 3'd5,
        S_DONE = 3'd6
    } state_t;

    state_t                       state_q;
    logic [AW-1:0]                index_q;
    logic [AW-1:0]                count_q;
    logic [15:0]                  word_q;
    logic [7:0]                   last_byte_q;
    logic                         ready_q;
    logic                         wr_en_q;
    logic [AW-1:0]                wr_addr_q;
    logic [INSTRUCTION_WIDTH-1:0] wr_data_q;
    logic                         busy_q;
    logic                         done_q;
    logic                         error_q;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]                   xor_q;
`endif

    logic          byte_fire;
    logic [AW-1:0] index_inc;

    assign byte_fire = i_byte_valid & ready_q;
    assign index_inc = index_q + 1'b1;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            index_q     <= '0;
            count_q     <= '0;
            word_q      <= '0;
            last_byte_q <= '0;
            ready_q     <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            xor_q       <= '0;
`endif
        end else begin
            // Write strobe is a single-cycle pulse raised only from B2.
            wr_en_q <= 1'b0;
            if (byte_fire) begin
                last_byte_q <= i_byte;
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            // Checksum covers every payload byte in full, including the bits
            // that are dropped from the third byte of each word.
            if (byte_fire && (state_q == S_B0 || state_q == S_B1 || state_q == S_B2)) begin
                xor_q <= xor_q ^ i_byte;
            end
`endif
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        done_q  <= 1'b0;
                        error_q <= 1'b0;
                        count_q <= i_word_count;
                        index_q <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
                        xor_q   <= '0;
`endif
                        if (i_word_count == '0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else if ({1'b0, i_word_count} > MEM_SIZE_L) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            error_q <= 1'b1;
                        end else begin
                            state_q <= S_B0;
                            busy_q  <= 1'b1;
                            ready_q <= 1'b1;
                        end
                    end
                end
                S_B0: begin
                    if (byte_fire) begin
                        word_q[7:0] <= i_byte;
                        state_q     <= S_B1;
                    end
                end
                S_B1: begin
                    if (byte_fire) begin
                        word_q[15:8] <= i_byte;
                        state_q      <= S_B2;
                    end
                end
                S_B2: begin
                    if (byte_fire) begin
                        // Only byte[1:0] fit in an 18-bit word.
                        wr_data_q <= {i_byte[1:0], word_q};
                        wr_addr_q <= MEM_BASE_ADDR + index_q;
                        wr_en_q   <= 1'b1;
                        ready_q   <= 1'b0;
                        state_q   <= S_WR;
                    end
                end
                S_WR: begin
                    index_q <= index_inc;
                    if (index_inc < count_q) begin
                        state_q <= S_B0;
                        ready_q <= 1'b1;
                    end else begin
`ifdef PROG_LOADER_CHECKSUM_EN
                        state_q <= S_CHK;
                        ready_q <= 1'b1;
`else
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
`endif
                    end
                end
`ifdef PROG_LOADER_CHECKSUM_EN
                S_CHK: begin
                    if (byte_fire) begin
                        state_q <= S_DONE;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        error_q <= (i_byte != xor_q);
                    end
                end
`endif
                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_byte_ready = ready_q;
    assign o_wr_en      = wr_en_q;
    assign o_wr_addr    = wr_addr_q;
    assign o_wr_data    = wr_data_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_error      = error_q;
    assign o_dbg_state  = state_q;
    assign o_dbg_byte   = last_byte_q;

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;

    // ---------------------------------------------------------------- clock/reset
    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_start = 1'b0;
    logic [13:0] i_word_count = '0;
    logic        i_byte_valid = 1'b0;
    logic [7:0]  i_byte = '0;
    logic        o_byte_ready, o_wr_en, o_busy, o_done, o_error;
    logic [13:0] o_wr_addr;
    logic [17:0] o_wr_data;
    logic [2:0]  o_dbg_state;
    logic [7:0]  o_dbg_byte;

    always #5 i_clk = ~i_clk;

    prog_loader dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_start      (i_start),
        .i_word_count (i_word_count),
        .i_byte_valid (i_byte_valid),
        .i_byte       (i_byte),
        .o_byte_ready (o_byte_ready),
        .o_wr_en      (o_wr_en),
        .o_wr_addr    (o_wr_addr),
        .o_wr_data    (o_wr_data),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_error      (o_error),
        .o_dbg_state  (o_dbg_state),
        .o_dbg_byte   (o_dbg_byte)
    );

    // ---------------------------------------------------------------- scoreboard
    int          tests = 0;
    int          fails = 0;
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];

    // Write strobe is registered, so it is stable around the falling edge.
    always @(negedge i_clk) begin
        if (o_wr_en) got_q.push_back({o_wr_addr, o_wr_data});
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_writes(input string tag);
        chk({tag, "_nwrites"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk({tag, "_write"}, got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    // ---------------------------------------------------------------- drivers
    // All driver tasks are entered and left on a falling edge.
    task automatic start_load(input logic [13:0] cnt);
        i_start      = 1'b1;
        i_word_count = cnt;
        @(negedge i_clk);
        i_start      = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        i_byte_valid = 1'b1;
        i_byte       = b;
        while (!o_byte_ready && n < 50) begin
            @(negedge i_clk);
            n++;
        end
        if (n >= 50) chk("byte_ready_timeout", 32'(n), 32'd0);
        @(negedge i_clk);
        i_byte_valid = 1'b0;
    endtask

    // Checksum byte: only exists when the checksum feature is built in.
    task automatic send_csum(input logic [7:0] b);
`ifdef PROG_LOADER_CHECKSUM_EN
        send_byte(b);
`else
        i_byte = b;
`endif
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!o_done && n < 40) begin
            @(negedge i_clk);
            n++;
        end
        if (n >= 40) chk({tag, "_done_timeout"}, 32'(n), 32'd0);
    endtask

    // ---------------------------------------------------------------- directed steps
    initial begin
        repeat (3) @(negedge i_clk);
        // Reset state
        chk("rst_busy",  32'(o_busy), 32'd0);
        chk("rst_done",  32'(o_done), 32'd0);
        chk("rst_ready", 32'(o_byte_ready), 32'd0);
        chk("rst_wr_en", 32'(o_wr_en), 32'd0);
        chk("rst_addr",  32'(o_wr_addr), 32'd0);
        i_rst = 1'b0;
        @(negedge i_clk);

        // Two words, little-endian packing, byte[7:2] of third byte dropped
        start_load(14'd2);
        chk("a_busy",  32'(o_busy), 32'd1);
        chk("a_ready", 32'(o_byte_ready), 32'd1);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'h02);
        send_csum(8'h13);
        wait_done("a");
        exp_q.push_back({14'h2000, 18'h30201});
        exp_q.push_back({14'h2001, 18'h2BBAA});
        check_writes("a");
        chk("a_done",  32'(o_done), 32'd1);
        chk("a_error", 32'(o_error), 32'd0);
        chk("a_busy_end", 32'(o_busy), 32'd0);

        // Zero-count load finishes on the next cycle without writes
        start_load(14'd0);
        chk("b_done",  32'(o_done), 32'd1);
        chk("b_error", 32'(o_error), 32'd0);
        chk("b_busy",  32'(o_busy), 32'd0);
        repeat (3) @(negedge i_clk);
        check_writes("b");

        // Oversized count is rejected
        start_load(14'd8193);
        chk("c_done",  32'(o_done), 32'd1);
        chk("c_error", 32'(o_error), 32'd1);
        chk("c_ready", 32'(o_byte_ready), 32'd0);
        repeat (4) @(negedge i_clk);
        chk("c_ready_hold", 32'(o_byte_ready), 32'd0);
        check_writes("c");

        // Largest legal count is accepted; abort via reset afterwards
        start_load(14'd8192);
        chk("m_busy",  32'(o_busy), 32'd1);
        chk("m_error", 32'(o_error), 32'd0);
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);

        // Gapped valid, plus a start request while busy that must be ignored
        start_load(14'd3);
        chk("d_error_clr", 32'(o_error), 32'd0);
        start_load(14'd0);
        chk("d_start_ignored_busy", 32'(o_busy), 32'd1);
        chk("d_start_ignored_done", 32'(o_done), 32'd0);
        send_byte(8'h10); @(negedge i_clk);
        send_byte(8'h20); @(negedge i_clk);
        send_byte(8'h01); @(negedge i_clk);
        send_byte(8'h30); @(negedge i_clk);
        send_byte(8'h40); @(negedge i_clk);
        send_byte(8'hFE); @(negedge i_clk);
        send_byte(8'hFF); @(negedge i_clk);
        send_byte(8'hFF); @(negedge i_clk);
        send_byte(8'hFF); @(negedge i_clk);
        send_csum(8'h40);
        wait_done("d");
        exp_q.push_back({14'h2000, 18'h12010});
        exp_q.push_back({14'h2001, 18'h24030});
        exp_q.push_back({14'h2002, 18'h3FFFF});
        check_writes("d");
        chk("d_addr_hold", 32'(o_wr_addr), 32'h2002);
        chk("d_data_hold", 32'(o_wr_data), 32'h3FFFF);

        // Asynchronous reset in the middle of a word
        start_load(14'd2);
        send_byte(8'hDE); send_byte(8'hAD);
        #2 i_rst = 1'b1;
        #1;
        chk("e_rst_busy",  32'(o_busy), 32'd0);
        chk("e_rst_ready", 32'(o_byte_ready), 32'd0);
        chk("e_rst_state", 32'(o_dbg_state), 32'd0);
        @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);
        start_load(14'd1);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h03);
        send_csum(8'h30);
        wait_done("e");
        exp_q.push_back({14'h2000, 18'h32211});
        check_writes("e");
        chk("e_error", 32'(o_error), 32'd0);

`ifdef PROG_LOADER_CHECKSUM_EN
        // Checksum mismatch: writes stand, error flagged
        start_load(14'd1);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        send_byte(8'h04);
        wait_done("f");
        exp_q.push_back({14'h2000, 18'h30201});
        check_writes("f");
        chk("f_error", 32'(o_error), 32'd1);
        // Checksum match
        start_load(14'd1);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        send_byte(8'h00);
        wait_done("g");
        exp_q.push_back({14'h2000, 18'h30201});
        check_writes("g");
        chk("g_error", 32'(o_error), 32'd0);
`else
        // Without checksum, done follows the last write directly
        start_load(14'd1);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        chk("f_wr_en", 32'(o_wr_en), 32'd1);
        @(negedge i_clk);
        chk("f_done",  32'(o_done), 32'd1);
        chk("f_ready", 32'(o_byte_ready), 32'd0);
        exp_q.push_back({14'h2000, 18'h30201});
        check_writes("f");
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
